// File: rtl/mips_pkg.sv
// Shared encodings and types for the single-cycle MIPS subset core.
package mips_pkg;
  localparam logic [31:0] TEXT_BASE_DEF = 32'h0000_3000;
  localparam logic [31:0] DATA_BASE_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;
endpackage

// File: rtl/mips_alu.sv
// Combinational ALU; shifts operate on i_b by i_shamt.
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_y
);
  // NOTE: o_y gets a default before the case so no path through this block infers a latch.
  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_NOR:  o_y = ~(i_a | i_b);
      ALU_SLT:  o_y = {31'b0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_y = {31'b0, i_a < i_b};
      ALU_SLL:  o_y = i_b << i_shamt;
      ALU_SRL:  o_y = i_b >> i_shamt;
      ALU_SRA:  o_y = $unsigned($signed(i_b) >>> i_shamt);
      ALU_LUI:  o_y = {i_b[15:0], 16'h0000};
      default:  o_y = '0;
    endcase
  end
endmodule

// File: rtl/mips_dmem.sv
// Data RAM with little-endian byte/half/word stores and a combinational word read.
module mips_dmem
  import mips_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = 32'h0000_0000,
  parameter int          DMEM_WORDS = 1024,
  localparam int         DAW        = $clog2(DMEM_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  mem_size_e   i_size,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);
  logic [31:0]    dataMem [0:DMEM_WORDS-1];
  logic [31:0]    w_off;
  logic           w_hit;
  logic [DAW-1:0] w_idx;

  assign w_off   = i_addr - DATA_BASE;
  assign w_hit   = w_off < 32'(DMEM_WORDS * 4);
  assign w_idx   = w_off[DAW+1:2];
  assign o_rdata = w_hit ? dataMem[w_idx] : 32'h0;

  // Contents survive reset; reset only blocks a store issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && i_we && w_hit) begin
      case (i_size)
        SZ_B:    dataMem[w_idx][{w_off[1:0], 3'b000} +: 8] <= i_wdata[7:0];
        SZ_H:    if (w_off[1]) dataMem[w_idx][31:16] <= i_wdata[15:0];
                 else          dataMem[w_idx][15:0]  <= i_wdata[15:0];
        default: dataMem[w_idx] <= i_wdata;
      endcase
    end
  end
endmodule

// File: rtl/mips_imem.sv
// Instruction memory with combinational fetch; misaligned or out-of-range PC fetches a nop.
module mips_imem #(
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 1024,
  localparam int         IAW        = $clog2(IMEM_WORDS)
) (
  input  logic           clk,
  input  logic [31:0]    i_pc,
  output logic [31:0]    o_instr,
  input  logic           i_we,
  input  logic [IAW-1:0] i_waddr,
  input  logic [31:0]    i_wdata
);
  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] w_off;
  logic        w_hit;

  assign w_off   = i_pc - TEXT_BASE;
  assign w_hit   = (w_off < 32'(IMEM_WORDS * 4)) && (w_off[1:0] == 2'b00);
  assign o_instr = w_hit ? imem[w_off[IAW+1:2]] : 32'h0;

  // Program load port; the core ties it off and the image is loaded from outside.
  always_ff @(posedge clk)
    if (i_we) imem[i_waddr] <= i_wdata;
endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational reads, one write port, $0 hard-wired to zero.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd
);
  logic [31:0] rf [0:31];

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'h0 : rf[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'h0 : rf[i_ra2];

  // NOTE: the register file is architecturally cleared by reset, unlike the RAMs, so it is built from flops.
  // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (i_we && i_wa != 5'd0) begin
      rf[i_wa] <= i_wd;
    end
  end
endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS subset CPU. Define MIPS_BRANCH_EN to add beq/bne/j.
module mips_core
  import mips_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEF,
  parameter logic [31:0] DATA_BASE  = DATA_BASE_DEF,
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  output logic [31:0] AnInstruction
);
  logic [31:0] r_pc;
  logic [31:0] w_instr, w_pc_plus4, w_next_pc;
  logic [31:0] w_rs_data, w_rt_data, w_sext, w_zext, w_ea;
  logic [31:0] w_alu_b, w_alu_y, w_dm_rdata, w_ld_data, w_wb_data;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_alu_shamt, w_wdest;
  logic [15:0] w_imm, w_ld_half;
  logic [7:0]  w_ld_byte;
  logic        w_reg_we, w_mem_we, w_is_load, w_ld_signed;
  alu_op_e     w_alu_op;
  mem_size_e   w_size;

  assign w_op       = w_instr[31:26];
  assign w_rs       = w_instr[25:21];
  assign w_rt       = w_instr[20:16];
  assign w_rd       = w_instr[15:11];
  assign w_shamt    = w_instr[10:6];
  assign w_funct    = w_instr[5:0];
  assign w_imm      = w_instr[15:0];
  assign w_sext     = {{16{w_imm[15]}}, w_imm};
  assign w_zext     = {16'h0000, w_imm};
  assign w_ea       = w_rs_data + w_sext;
  assign w_pc_plus4 = r_pc + 32'd4;

  assign PC            = r_pc;
  assign AnInstruction = w_instr;

`ifdef MIPS_BRANCH_EN
  logic [31:0] w_br_target, w_j_target;
  assign w_br_target = w_pc_plus4 + {w_sext[29:0], 2'b00};
  assign w_j_target  = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
`endif

  always_comb begin
    w_alu_op    = ALU_ADD;
    w_alu_b     = w_rt_data;
    w_alu_shamt = w_shamt;
    w_wdest     = w_rd;
    w_reg_we    = 1'b0;
    w_mem_we    = 1'b0;
    w_is_load   = 1'b0;
    w_ld_signed = 1'b0;
    w_size      = SZ_W;
    w_next_pc   = w_pc_plus4;
    case (w_op)
      OP_RTYPE: begin
        w_reg_we = 1'b1;
        case (w_funct)
          FN_ADD, FN_ADDU: w_alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: w_alu_op = ALU_SUB;
          FN_AND:  w_alu_op = ALU_AND;
          FN_OR:   w_alu_op = ALU_OR;
          FN_NOR:  w_alu_op = ALU_NOR;
          FN_SLT:  w_alu_op = ALU_SLT;
          FN_SLTU: w_alu_op = ALU_SLTU;
          FN_SLL:  w_alu_op = ALU_SLL;
          FN_SRL:  w_alu_op = ALU_SRL;
          FN_SRA:  w_alu_op = ALU_SRA;
          FN_SLLV: begin w_alu_op = ALU_SLL; w_alu_shamt = w_rs_data[4:0]; end
          FN_SRLV: begin w_alu_op = ALU_SRL; w_alu_shamt = w_rs_data[4:0]; end
          FN_SRAV: begin w_alu_op = ALU_SRA; w_alu_shamt = w_rs_data[4:0]; end
          default: w_reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin w_reg_we = 1'b1; w_wdest = w_rt; w_alu_b = w_sext; end
      OP_ORI:  begin w_reg_we = 1'b1; w_wdest = w_rt; w_alu_b = w_zext; w_alu_op = ALU_OR; end
      OP_LUI:  begin w_reg_we = 1'b1; w_wdest = w_rt; w_alu_b = w_zext; w_alu_op = ALU_LUI; end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        w_reg_we    = 1'b1;
        w_wdest     = w_rt;
        w_is_load   = 1'b1;
        w_ld_signed = (w_op == OP_LB) || (w_op == OP_LH);
        w_size      = (w_op == OP_LW) ? SZ_W :
                      (w_op == OP_LH || w_op == OP_LHU) ? SZ_H : SZ_B;
      end
      OP_SB: begin w_mem_we = 1'b1; w_size = SZ_B; end
      OP_SH: begin w_mem_we = 1'b1; w_size = SZ_H; end
      OP_SW: begin w_mem_we = 1'b1; w_size = SZ_W; end
`ifdef MIPS_BRANCH_EN
      OP_BEQ: if (w_rs_data == w_rt_data) w_next_pc = w_br_target;
      OP_BNE: if (w_rs_data != w_rt_data) w_next_pc = w_br_target;
      OP_J:   w_next_pc = w_j_target;
`endif
      default: ;
    endcase
  end

  // Load lanes mirror the store lanes: byte at ea[1:0], half at ea[1].
  assign w_ld_byte = w_dm_rdata[{w_ea[1:0], 3'b000} +: 8];
  assign w_ld_half = w_ea[1] ? w_dm_rdata[31:16] : w_dm_rdata[15:0];

  always_comb begin
    case (w_size)
      SZ_B:    w_ld_data = w_ld_signed ? {{24{w_ld_byte[7]}}, w_ld_byte} : {24'h0, w_ld_byte};
      SZ_H:    w_ld_data = w_ld_signed ? {{16{w_ld_half[15]}}, w_ld_half} : {16'h0, w_ld_half};
      default: w_ld_data = w_dm_rdata;
    endcase
  end

  assign w_wb_data = w_is_load ? w_ld_data : w_alu_y;

  always_ff @(posedge clk) begin
    if (rst) r_pc <= TEXT_BASE;
    else     r_pc <= w_next_pc;
  end

  mips_imem #(.TEXT_BASE(TEXT_BASE), .IMEM_WORDS(IMEM_WORDS)) U_IM (
    .clk(clk), .i_pc(r_pc), .o_instr(w_instr),
    .i_we(1'b0), .i_waddr('0), .i_wdata('0)
  );

  mips_regfile U_RF (
    .clk(clk), .rst(rst),
    .i_ra1(w_rs), .i_ra2(w_rt), .o_rd1(w_rs_data), .o_rd2(w_rt_data),
    .i_we(w_reg_we), .i_wa(w_wdest), .i_wd(w_wb_data)
  );

  mips_dmem #(.DATA_BASE(DATA_BASE), .DMEM_WORDS(DMEM_WORDS)) U_DM (
    .clk(clk), .rst(rst), .i_addr(w_ea), .i_we(w_mem_we), .i_size(w_size),
    .i_wdata(w_rt_data), .o_rdata(w_dm_rdata)
  );

  mips_alu U_ALU (
    .i_op(w_alu_op), .i_a(w_rs_data), .i_b(w_alu_b), .i_shamt(w_alu_shamt), .o_y(w_alu_y)
  );
endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: loads a program through the hierarchy and checks state tables.
module tb_mips_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc, instr;

  int n_cmp = 0;
  int n_err = 0;

  mips_core dut (.clk(clk), .rst(rst), .PC(pc), .AnInstruction(instr));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                       input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [0:32];
  vec_t        rf_vec [$];
  vec_t        dm_vec [$];

  initial begin
    prog[0]  = i_op(6'h0F, 0, 1, 16'h1234);           // lui  $1,0x1234
    prog[1]  = i_op(6'h0D, 1, 1, 16'h5678);           // ori  $1,$1,0x5678
    prog[2]  = i_op(6'h08, 0, 2, 16'hFFFF);           // addi $2,$0,-1
    prog[3]  = i_op(6'h08, 0, 3, 16'h0001);           // addi $3,$0,1
    prog[4]  = r_op(2, 3, 4, 0, 6'h2A);               // slt  $4,$2,$3
    prog[5]  = r_op(2, 3, 5, 0, 6'h2B);               // sltu $5,$2,$3
    prog[6]  = r_op(0, 0, 6, 0, 6'h27);               // nor  $6,$0,$0
    prog[7]  = r_op(3, 2, 7, 0, 6'h23);               // subu $7,$3,$2
    prog[8]  = i_op(6'h0F, 0, 8, 16'h8000);           // lui  $8,0x8000
    prog[9]  = r_op(0, 8, 9, 4, 6'h03);               // sra  $9,$8,4
    prog[10] = r_op(0, 8, 10, 4, 6'h02);              // srl  $10,$8,4
    prog[11] = r_op(3, 8, 11, 0, 6'h04);              // sllv $11,$8,$3
    prog[12] = i_op(6'h0F, 0, 12, 16'h1234);          // lui  $12,0x1234
    prog[13] = i_op(6'h0D, 12, 12, 16'h5680);         // ori  $12,$12,0x5680
    prog[14] = i_op(6'h2B, 0, 12, 16'h0000);          // sw   $12,0($0)
    prog[15] = i_op(6'h20, 0, 13, 16'h0000);          // lb   $13,0($0)
    prog[16] = i_op(6'h24, 0, 14, 16'h0000);          // lbu  $14,0($0)
    prog[17] = i_op(6'h21, 0, 15, 16'h0002);          // lh   $15,2($0)
    prog[18] = i_op(6'h25, 0, 16, 16'h0000);          // lhu  $16,0($0)
    prog[19] = i_op(6'h28, 0, 3, 16'h0005);           // sb   $3,5($0)
    prog[20] = i_op(6'h29, 0, 2, 16'h000A);           // sh   $2,10($0)
    prog[21] = i_op(6'h08, 0, 0, 16'h0005);           // addi $0,$0,5
    prog[22] = r_op(1, 3, 17, 0, 6'h20);              // add  $17,$1,$3
    prog[23] = r_op(3, 8, 18, 0, 6'h25);              // or   $18,$3,$8
    prog[24] = r_op(0, 3, 19, 0, 6'h22);              // sub  $19,$0,$3
    prog[25] = r_op(3, 8, 20, 0, 6'h07);              // srav $20,$8,$3
    prog[26] = r_op(3, 8, 21, 0, 6'h06);              // srlv $21,$8,$3
    prog[27] = r_op(0, 3, 22, 31, 6'h00);             // sll  $22,$3,31
    prog[28] = i_op(6'h23, 0, 23, 16'h0000);          // lw   $23,0($0)
    prog[29] = i_op(6'h3F, 0, 24, 16'h1234);          // unknown opcode
    prog[30] = i_op(6'h09, 0, 25, 16'h0007);          // addiu: not in the subset
    prog[31] = i_op(6'h04, 0, 0, 16'h0001);           // beq  $0,$0,+1
    prog[32] = i_op(6'h08, 0, 26, 16'h0009);          // addi $26,$0,9 (skipped if branches exist)

    rf_vec = '{
      '{"lui_ori",  1, 32'h1234_5678}, '{"addi_m1", 2, 32'hFFFF_FFFF}, '{"addi_1", 3, 32'h0000_0001},
      '{"slt",      4, 32'h0000_0001}, '{"sltu",    5, 32'h0000_0000}, '{"nor",    6, 32'hFFFF_FFFF},
      '{"subu",     7, 32'h0000_0002}, '{"lui_neg", 8, 32'h8000_0000}, '{"sra",    9, 32'hF800_0000},
      '{"srl",     10, 32'h0800_0000}, '{"sllv",   11, 32'h0000_0000}, '{"word",  12, 32'h1234_5680},
      '{"lb",      13, 32'hFFFF_FF80}, '{"lbu",    14, 32'h0000_0080}, '{"lh",    15, 32'h0000_1234},
      '{"lhu",     16, 32'h0000_5680}, '{"r0_zero", 0, 32'h0000_0000}, '{"add",   17, 32'h1234_5679},
      '{"or",      18, 32'h8000_0001}, '{"sub",    19, 32'hFFFF_FFFF}, '{"srav",  20, 32'hC000_0000},
      '{"srlv",    21, 32'h4000_0000}, '{"sll31",  22, 32'h8000_0000}, '{"lw",    23, 32'h1234_5680},
      '{"unk_op",  24, 32'h0000_0000}, '{"addiu",  25, 32'h0000_0000},
`ifdef MIPS_BRANCH_EN
      '{"beq_skip", 26, 32'h0000_0000}
`else
      '{"beq_nop",  26, 32'h0000_0009}
`endif
    };
    dm_vec = '{
      '{"sw_word", 0, 32'h1234_5680}, '{"sb_lane1", 1, 32'h0000_0100}, '{"sh_upper", 2, 32'hFFFF_0000},
      '{"dm_other", 3, 32'h0000_0000}
    };

    for (int i = 0; i < 1024; i++) begin
      dut.U_IM.imem[i]    = 32'h0;
      dut.U_DM.dataMem[i] = 32'h0;
    end
    for (int i = 0; i < 33; i++) dut.U_IM.imem[i] = prog[i];
    for (int i = 0; i < 32; i++) dut.U_RF.rf[i] = 32'hDEAD_0000 + 32'(i);

    // Reset: PC to TEXT_BASE, registers cleared, lui at 0x3000 must not write.
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_rf1", dut.U_RF.rf[1], 32'h0);
    check("rst_rf31", dut.U_RF.rf[31], 32'h0);
    check("fetch0", instr, prog[0]);
    rst = 1'b0;

    step();
    check("pc_1", pc, 32'h0000_3004);
    check("rf1_lui", dut.U_RF.rf[1], 32'h1234_0000);
    step();
    check("pc_2", pc, 32'h0000_3008);
    check("rf1_ori", dut.U_RF.rf[1], 32'h1234_5678);

    // Finish the program plus trailing zero words, which execute as nops.
    repeat (38) step();

    foreach (rf_vec[i]) check(rf_vec[i].name, dut.U_RF.rf[rf_vec[i].idx], rf_vec[i].exp);
    foreach (dm_vec[i]) check(dm_vec[i].name, dut.U_DM.dataMem[dm_vec[i].idx], dm_vec[i].exp);
    check("pc_end", pc, 32'h0000_3000 + 32'd160);

    // Restart, stop with the sb at PC, then reset: the store must be squashed.
    rst = 1'b1;
    step();
    check("rst2_pc", pc, 32'h0000_3000);
    check("rst2_rf23", dut.U_RF.rf[23], 32'h0);
    dut.U_DM.dataMem[1] = 32'h0;
    rst = 1'b0;
    repeat (19) step();
    check("pc_at_sb", pc, 32'h0000_304C);
    check("fetch_sb", instr, prog[19]);
    rst = 1'b1;
    step();
    check("rst3_pc", pc, 32'h0000_3000);
    check("rst3_rf3", dut.U_RF.rf[3], 32'h0);
    check("rst3_rf12", dut.U_RF.rf[12], 32'h0);
    check("rst3_sb_blocked", dut.U_DM.dataMem[1], 32'h0);
    check("rst3_dm0_kept", dut.U_DM.dataMem[0], 32'h1234_5680);
    check("rst3_dm2_kept", dut.U_DM.dataMem[2], 32'hFFFF_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mips_core.md
Name: mips_core

Overview:
- Single-cycle 32-bit MIPS subset CPU with internal instruction ROM, register file and data RAM.
- Each clock fetches, executes and writes back exactly one instruction.
- Top of the CPU hierarchy. Benches load the program through the hierarchy and inspect registers and memory through the hierarchy.

Parameters:
- TEXT_BASE, 32'h0000_3000, reset PC and byte address of imem word 0.
- DATA_BASE, 32'h0000_0000, byte address of dmem word 0.
- IMEM_WORDS, 1024, instruction memory depth in words.
- DMEM_WORDS, 1024, data memory depth in words.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- PC  output  32  current program counter (debug).
- AnInstruction  output  32  instruction at PC (debug).

Behaviour:
- Fixed hierarchy names used by benches:
  - U_IM.imem: word array, loaded with $readmemh.
  - U_RF.rf[0:31]: register file.
  - U_DM.dataMem: word array, indexed by (addr-DATA_BASE)>>2.
- Reset (sync): PC <= TEXT_BASE; rf[1..31] <= 0. dmem and imem are untouched.
- Reset wins over any write in the same cycle.
- Normal cycle: PC <= PC+4.
- Instruction fetch is combinational: imem[(PC-TEXT_BASE)>>2].
- Out-of-range fetch returns 0 (nop).
- Register file reads are combinational. Writes happen on the rising edge. rf[0] always reads 0 and writes to it are ignored.
- R-type ops, result written to rd:
  - addu, add, subu, sub: add/sub wrap modulo 2^32; no overflow trap.
  - and, or, nor.
  - slt (signed), sltu (unsigned): result 1 or 0.
  - sll, srl, sra: shift amount from shamt.
  - sllv, srlv, srav: shift amount = rs[4:0]; sra/srav replicate the sign bit.
- I-type ops, result written to rt:
  - lui: imm<<16.
  - ori: zero-extended imm.
  - addi: sign-extended imm, wrap, no trap.
- Effective address for loads and stores = rs + sign-extended imm.
- Stores (sw, sh, sb) write on the rising edge with little-endian byte lanes:
  - sb writes the byte at addr[1:0].
  - sh writes half addr[1]; addr[0] is ignored.
  - sw ignores addr[1:0].
- Loads are combinational reads and write rt on the same edge:
  - lw: full word.
  - lh, lb: sign-extended.
  - lhu, lbu: zero-extended.
  - Lane selection matches the stores.
- Unknown opcode/funct: no register or memory write; PC advances.

Optional Feature:
- Macro MIPS_BRANCH_EN.
- Defined, adds three instructions:
  - beq, bne: target = PC+4+(sext(imm)<<2) when taken. No delay slot.
  - j: target = {PC+4[31:28], target26, 2'b00}.
- Undefined: these three opcodes are treated as unknown (PC+4, no writes).

Decomposition:
- Package mips_pkg: opcode and funct localparams, ALU-op enum, load/store size enum, TEXT_BASE/DATA_BASE defaults.
- Sub-modules instanced as U_IM (imem), U_RF (regfile), U_DM (dmem).
- Control and ALU logic live inside mips_core. One natural extra sub-module: mips_alu.

Test Plan:
- Reset, then lui $1,0x1234; ori $1,$1,0x5678 -> rf[1]=0x12345678. PC advances 0x3000, 0x3004, 0x3008.
- $2=-1 (addi $2,$0,-1), $3=1: slt $4,$2,$3 -> 1; sltu $5,$2,$3 -> 0; nor $6,$0,$0 -> 0xFFFFFFFF; subu $7,$3,$2 -> 2.
- $8=0x80000000: sra by 4 -> 0xF8000000; srl by 4 -> 0x08000000; sllv with $3=1 -> 0x00000000.
- sw 0x12345680 at 0x0 -> dataMem[0]=0x12345680. Then:
  - lb @0 -> 0xFFFFFF80; lbu @0 -> 0x00000080.
  - lh @2 -> 0x00001234; lhu @0 -> 0x00005680.
- sb $3 @0x5 and sh $2 @0xA -> dataMem[1]=0x00000100, dataMem[2]=0xFFFF0000. Other bytes unchanged.
- addi $0,$0,5 -> rf[0] stays 0. Assert rst mid-program -> PC=0x3000 next edge and registers cleared; dmem contents retained.
